fft_result_reader: RTL and testbench

FFT_RESULT_READER -- requirements
Module: fft_result_reader

---
 rtl/fft_result_reader_pkg.sv | 29 ++
 rtl/fft_result_reader_if.sv | 11 +
 rtl/fft_result_reader_rd_index_cnt.sv | 29 ++
 rtl/fft_result_reader.sv | 144 ++++++++++++++
 tb/tb_fft_result_reader.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_result_reader_pkg.sv
// Shared definitions for the FFT result reader: FSM state encoding and the
// address bit-reversal helper used for bit-reversed drains.
package fft_result_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

  localparam int MAX_W = 16;

  // Reverse the low w bits of v (bit i -> bit w-1-i); upper bits come back zero.
  function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        r[w-1-i] = v[i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_result_reader_if.sv
// Wishbone classic slave signals of the FFT result reader.
interface fft_result_reader_if #(parameter int DATA_W = 32);
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [DATA_W-1:0] wb_dat_o;
  logic              wb_ack_o;

  modport slave  (input wb_cyc_i, wb_stb_i, wb_we_i, output wb_dat_o, wb_ack_o);
  modport master (output wb_cyc_i, wb_stb_i, wb_we_i, input wb_dat_o, wb_ack_o);
endinterface

// File: rtl/fft_result_reader_rd_index_cnt.sv
// Frame word index: WIDTH-bit up-counter with enable and synchronous clear.
module rd_index_cnt #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Counter register; clear wins over enable.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/fft_result_reader.sv
// Drains a completed FFT frame from the result RAM through a Wishbone slave,
// one word per read, in linear or bit-reversed address order.
module fft_result_reader
  import fft_result_reader_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int DATA_W = 32
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 bitrev,
  input  logic                 abort,
  output logic [WIDTH-1:0]     ram_addr,
  output logic                 ram_rd,
  input  logic [DATA_W-1:0]    ram_data,
  fft_result_reader_if.slave   wb,
  output logic                 busy,
  output logic                 done
);

  localparam logic [WIDTH-1:0] LAST_IDX = {WIDTH{1'b1}};

  state_t            state_r, state_nxt_s;
  logic [WIDTH-1:0]  index_s, fetch_idx_s;
  logic [WIDTH-1:0]  ram_addr_r, ram_addr_nxt_s;
  logic [DATA_W-1:0] dat_r, dat_nxt_s;
  logic              ram_rd_r, ram_rd_nxt_s;
  logic              ack_r, ack_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              done_r, done_nxt_s;
  logic              bitrev_r, bitrev_nxt_s, fetch_rev_s;
  logic              rd_stb_s, wr_stb_s, is_last_s, start_ok_s;
  logic              word_ack_s, idle_ack_s, cnt_en_s, cnt_clr_s;

  assign rd_stb_s   = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_we_i;
  assign wr_stb_s   = wb.wb_cyc_i & wb.wb_stb_i & wb.wb_we_i;
  assign is_last_s  = (index_s == LAST_IDX);
  assign start_ok_s = (state_r == ST_IDLE) & start & ~abort;
  // ack_r gates every new ack so the acknowledge can never stay high two cycles.
  assign word_ack_s = (state_r == ST_VALID) & rd_stb_s & ~ack_r & ~abort;
  assign idle_ack_s = (state_r == ST_IDLE) & rd_stb_s & ~ack_r;
  assign cnt_clr_s  = abort | start_ok_s | ((state_r == ST_ACK) & is_last_s);
  assign cnt_en_s   = (state_r == ST_ACK) & ~is_last_s;

  rd_index_cnt #(.WIDTH(WIDTH)) u_index (
    .clock  (clock),
    .resetn (resetn),
    .en     (cnt_en_s),
    .clr    (cnt_clr_s),
    .count  (index_s)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort overrides everything, including start.
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_nxt_s = start ? ST_FETCH : ST_IDLE;
        ST_FETCH: state_nxt_s = ST_WAIT;
        ST_WAIT:  state_nxt_s = ST_VALID;
        ST_VALID: state_nxt_s = word_ack_s ? ST_ACK : ST_VALID;
        ST_ACK:   state_nxt_s = is_last_s ? ST_IDLE : ST_FETCH;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, derived from the state being entered.
  always_comb begin
    fetch_idx_s    = (state_r == ST_IDLE) ? '0 : index_s + WIDTH'(1);
    fetch_rev_s    = (state_r == ST_IDLE) ? bitrev : bitrev_r;
    ram_rd_nxt_s   = (state_nxt_s == ST_FETCH);
    ram_addr_nxt_s = ram_addr_r;
    if (ram_rd_nxt_s) begin
      if (fetch_rev_s) begin
        ram_addr_nxt_s = WIDTH'(bit_reverse(MAX_W'(fetch_idx_s), WIDTH));
      end else begin
        ram_addr_nxt_s = fetch_idx_s;
      end
    end else begin
      ram_addr_nxt_s = ram_addr_r;
    end
    ack_nxt_s = ~ack_r & (wr_stb_s | idle_ack_s | word_ack_s);
    if ((state_r == ST_WAIT) && !abort) begin
      dat_nxt_s = ram_data;
    end else if (idle_ack_s) begin
      dat_nxt_s = '0;
    end else begin
      dat_nxt_s = dat_r;
    end
    if (abort) begin
      busy_nxt_s = 1'b0;
    end else if (start_ok_s) begin
      busy_nxt_s = 1'b1;
    end else if ((state_r == ST_ACK) && is_last_s) begin
      busy_nxt_s = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    done_nxt_s   = ~abort & (state_r == ST_ACK) & is_last_s;
    bitrev_nxt_s = start_ok_s ? bitrev : bitrev_r;
  end

  // Output and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ram_addr_r <= '0;
      ram_rd_r   <= 1'b0;
      dat_r      <= '0;
      ack_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bitrev_r   <= 1'b0;
    end else begin
      ram_addr_r <= ram_addr_nxt_s;
      ram_rd_r   <= ram_rd_nxt_s;
      dat_r      <= dat_nxt_s;
      ack_r      <= ack_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      bitrev_r   <= bitrev_nxt_s;
    end
  end

  assign ram_addr    = ram_addr_r;
  assign ram_rd      = ram_rd_r;
  assign wb.wb_dat_o = dat_r;
  assign wb.wb_ack_o = ack_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench for fft_result_reader (WIDTH=3): table-driven frame drains
// plus hand-written sequences for reset, wait states, writes, abort and throughput.
module tb_fft_result_reader;

  logic        clock;
  logic        resetn;
  logic        start;
  logic        bitrev;
  logic        abort;
  logic [2:0]  ram_addr;
  logic        ram_rd;
  logic [31:0] ram_data;
  logic        busy;
  logic        done;

  fft_result_reader_if #(.DATA_W(32)) wb ();

  fft_result_reader #(.WIDTH(3), .DATA_W(32)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .bitrev   (bitrev),
    .abort    (abort),
    .ram_addr (ram_addr),
    .ram_rd   (ram_rd),
    .ram_data (ram_data),
    .wb       (wb),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic        rev;
    int          word;
    logic [2:0]  exp_addr;
    logic [31:0] exp_dat;
  } vec_t;

  int         chk_cnt;
  int         pass_cnt;
  int         done_cnt;
  logic       prev_ack;
  logic [2:0] fetch_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Result RAM model: word[a] = 0x10*a + 1, one cycle read latency.
  always @(posedge clock) begin
    if (ram_rd) begin
      ram_data <= ({29'd0, ram_addr} * 32'h10) + 32'h1;
      fetch_q.push_back(ram_addr);
    end
  end

  always @(posedge clock) begin
    if (resetn && done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  always @(negedge clock) begin
    if (resetn && wb.wb_ack_o) check("ack_gap", {31'd0, prev_ack}, 32'd0);
    prev_ack <= resetn & wb.wb_ack_o;
  end

  task automatic pulse_start(input logic rev);
    start  = 1'b1;
    bitrev = rev;
    @(negedge clock);
    start  = 1'b0;
    bitrev = ~rev;
  endtask

  task automatic wb_read(output logic [31:0] d, output int cyc);
    logic got;
    got = 1'b0;
    d   = '0;
    cyc = 0;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (wb.wb_ack_o) begin
        got = 1'b1; d = wb.wb_dat_o; cyc = i + 1;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
      end
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    if (!got) check("rd_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_write(output int cyc);
    logic got;
    got = 1'b0;
    cyc = 0;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (wb.wb_ack_o) begin
        got = 1'b1; cyc = i + 1;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
      end
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    if (!got) check("wr_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    vec_t        vecs[16];
    logic [2:0]  rev_order[8];
    logic [31:0] d;
    int          c, n, last_t, dc;
    logic [2:0]  a;

    chk_cnt = 0; pass_cnt = 0; done_cnt = 0; prev_ack = 1'b0;
    start = 1'b0; bitrev = 1'b0; abort = 1'b0; ram_data = '0;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;

    rev_order = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    for (int i = 0; i < 8; i++) begin
      vecs[i]     = '{1'b0, i, 3'(i), 32'h10 * i + 32'h1};
      vecs[i + 8] = '{1'b1, i, rev_order[i], 32'h10 * rev_order[i] + 32'h1};
    end

    resetn = 1'b1;
    #1 resetn = 1'b0;
    @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ram_rd", {31'd0, ram_rd}, 32'd0);
    check("rst_dat", wb.wb_dat_o, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Table: linear drain then bit-reversed drain.
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].word == 0) begin
        fetch_q.delete();
        pulse_start(vecs[i].rev);
        check("busy_after_start", {31'd0, busy}, 32'd1);
      end
      wb_read(d, c);
      check("tbl_data", d, vecs[i].exp_dat);
      if (fetch_q.size() > 0) begin
        a = fetch_q.pop_front();
        check("tbl_addr", {29'd0, a}, {29'd0, vecs[i].exp_addr});
      end else begin
        check("tbl_addr_missing", 32'd0, 32'd1);
      end
      check("tbl_done_low", {31'd0, done}, 32'd0);
      if (vecs[i].word == 7) begin
        @(negedge clock);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_fall", {31'd0, busy}, 32'd0);
        @(negedge clock);
        check("done_one_cycle", {31'd0, done}, 32'd0);
      end
    end

    // Read in IDLE: one-cycle ack with zero data.
    check("dat_before_idle_rd", wb.wb_dat_o, 32'h71);
    wb_read(d, c);
    check("idle_rd_data", d, 32'd0);
    check("idle_rd_lat", c, 32'd1);
    @(negedge clock);

    // Strobe held from FETCH across a whole frame: 4-cycle period.
    dc = done_cnt;
    pulse_start(1'b0);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
    n = 0; last_t = 0;
    for (int k = 1; k <= 60 && n < 8; k++) begin
      @(negedge clock);
      if (wb.wb_ack_o) begin
        if (n == 0) check("first_ack_t", k, 32'd3);
        else        check("b2b_period", k - last_t, 32'd4);
        check("b2b_data", wb.wb_dat_o, 32'h10 * n + 32'h1);
        last_t = k;
        n++;
        if (n == 8) begin
          wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        end
      end
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    check("b2b_count", n, 32'd8);
    @(negedge clock);
    check("b2b_done", {31'd0, done}, 32'd1);
    @(negedge clock);
    check("b2b_done_cnt", done_cnt - dc, 32'd1);

    // Write mid-frame, wait states in VALID, then abort after 3 acks.
    pulse_start(1'b0);
    wb_read(d, c);
    check("w_word0", d, 32'h01);
    @(negedge clock);
    wb_write(c);
    check("wr_lat", c, 32'd1);
    check("wr_dat_kept", wb.wb_dat_o, 32'h01);
    repeat (5) @(negedge clock);
    check("valid_hold_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    check("valid_hold_busy", {31'd0, busy}, 32'd1);
    wb_read(d, c);
    check("valid_rd_lat", c, 32'd1);
    check("w_word1", d, 32'h11);
    wb_read(d, c);
    check("w_word2", d, 32'h21);
    dc = done_cnt;
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ram_rd", {31'd0, ram_rd}, 32'd0);
    repeat (3) @(negedge clock);
    check("abort_no_done", done_cnt - dc, 32'd0);
    wb_read(d, c);
    check("abort_idle_lat", c, 32'd1);
    check("abort_idle_dat", d, 32'd0);
    fetch_q.delete();
    pulse_start(1'b0);
    wb_read(d, c);
    check("restart_word0", d, 32'h01);
    if (fetch_q.size() > 0) begin
      a = fetch_q.pop_front();
      check("restart_addr", {29'd0, a}, 32'd0);
    end else begin
      check("restart_addr_missing", 32'd0, 32'd1);
    end

    // Reset asserted while a word sits in VALID.
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    dc = done_cnt;
    pulse_start(1'b1);
    repeat (2) @(negedge clock);
    check("pre_rst_dat", wb.wb_dat_o, 32'h01);
    resetn = 1'b0;
    #1;
    check("arst_addr", {29'd0, ram_addr}, 32'd0);
    check("arst_rd", {31'd0, ram_rd}, 32'd0);
    check("arst_dat", wb.wb_dat_o, 32'd0);
    check("arst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    wb_read(d, c);
    check("post_rst_lat", c, 32'd1);
    check("post_rst_dat", d, 32'd0);
    check("post_rst_no_done", done_cnt - dc, 32'd0);
    fetch_q.delete();
    pulse_start(1'b0);
    wb_read(d, c);
    check("post_rst_word0", d, 32'h01);
    @(negedge clock);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
